// File: rtl/noc_port_arbiter_pkg.sv
// Shared definitions for the NoC output-port arbiter: requester indices,
// FSM state encoding and flit tail position.
package noc_pkg;

   localparam int unsigned REQ_E = 0;
   localparam int unsigned REQ_W = 1;
   localparam int unsigned REQ_L = 2;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned TAIL_BIT      = DEFAULT_WIDTH - 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arbState_t;

endpackage

// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between requester FIFOs, the arbiter and the destination FIFO.
// The arbiter connects through master; the surrounding FIFOs/bench through slave.
interface noc_port_arbiter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 3
);
   logic [NREQ-1:0]  req;
   logic [WIDTH-1:0] dataIn0;
   logic [WIDTH-1:0] dataIn1;
   logic [WIDTH-1:0] dataIn2;
   logic             destFull;
   logic             destAlmostFull;
   logic [NREQ-1:0]  read;
   logic [WIDTH-1:0] dataOut;
   logic             writeOut;
   logic [NREQ-1:0]  grant;
   logic             busy;

   modport master (
      input  req, dataIn0, dataIn1, dataIn2, destFull, destAlmostFull,
      output read, dataOut, writeOut, grant, busy
   );

   modport slave (
      output req, dataIn0, dataIn1, dataIn2, destFull, destAlmostFull,
      input  read, dataOut, writeOut, grant, busy
   );
endinterface

// File: rtl/noc_port_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit searching from ptr upward,
// wrapping modulo NREQ. Purely combinational.
module rr_pick #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic            valid
);
   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = PW'((32'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      valid = found;
   end
endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port arbiter: round-robin between E/W/L between packets,
// locks onto one requester until its tail flit is forwarded.
module noc_port_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 3
) (
   input logic                clk,
   input logic                reset,
   noc_port_arbiter_if.master bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arbState_t        state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    lock;
   logic [PW-1:0]    selIdx;
   logic [PW-1:0]    nextSel;
   logic [NREQ-1:0]  pick;
   logic [NREQ-1:0]  lockOneHot;
   logic [NREQ-1:0]  selOneHot;
   logic             pickValid;
   logic             canSend;
   logic             xfer;
   logic [WIDTH-1:0] flit;

   rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
      .req   (bus.req),
      .ptr   (ptr),
      .pick  (pick),
      .valid (pickValid)
   );

   always_comb begin
      lockOneHot       = '0;
      lockOneHot[lock] = 1'b1;
      selIdx           = lock;
      if (state == IDLE) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) selIdx = PW'(i);
         end
      end
      nextSel = (selIdx == PW'(NREQ - 1)) ? '0 : selIdx + PW'(1);

      // The in-flight write still occupies the last free slot when almost full.
      canSend   = !bus.destFull && !(bus.destAlmostFull && bus.writeOut);
      // Gating with reset keeps the combinational pop strobe quiet during reset.
      xfer      = reset && canSend && ((state == IDLE) ? pickValid : bus.req[lock]);
      selOneHot = (state == IDLE) ? pick : lockOneHot;
      bus.read  = xfer ? selOneHot : '0;
      bus.grant = (state == BUSY) ? lockOneHot : bus.read;
      bus.busy  = (state == BUSY);

      case (selIdx)
         PW'(REQ_E): flit = bus.dataIn0;
         PW'(REQ_W): flit = bus.dataIn1;
         default:    flit = bus.dataIn2;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ptr          <= '0;
         lock         <= '0;
         bus.dataOut  <= '0;
         bus.writeOut <= 1'b0;
      end else begin
         bus.writeOut <= xfer;
         if (xfer) begin
            bus.dataOut <= flit;
            case (state)
               IDLE: begin
                  if (flit[WIDTH-1]) begin
                     ptr <= nextSel;
                  end else begin
                     state <= BUSY;
                     lock  <= selIdx;
                  end
               end
               BUSY: begin
                  if (flit[WIDTH-1]) begin
                     state <= IDLE;
                     ptr   <= nextSel;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/noc_port_arbiter.md
NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, flit width in bits; bit WIDTH-1 is the tail flag (1 = last flit of packet).
REQ-002 Parameter NREQ, default 3, number of requesters, fixed index order 0=E, 1=W, 2=L.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 req  input  NREQ  per-requester FIFO non-empty flag; head flit is valid.
REQ-006 dataIn0/dataIn1/dataIn2  input  WIDTH  head flit of requester E/W/L.
REQ-007 destFull  input  1  destination FIFO full.
REQ-008 destAlmostFull  input  1  destination FIFO has one free slot.
REQ-009 read  output  NREQ  one-hot pop strobe to the served requester FIFO; combinational.
REQ-010 dataOut  output  WIDTH  registered flit to the destination FIFO.
REQ-011 writeOut  output  1  registered write strobe qualifying dataOut.
REQ-012 grant  output  NREQ  one-hot current owner.
REQ-013 busy  output  1  high while a multi-flit packet holds the port.

Function
REQ-014 can_send SHALL equal !destFull && !(destAlmostFull && writeOut), covering the in-flight write.
REQ-015 FSM states SHALL be IDLE and BUSY; state, lock index and RR pointer ptr (0..NREQ-1) SHALL be registered.
REQ-016 In IDLE with can_send and any req, sel SHALL be the first requester with req set, searching ptr, ptr+1, ... modulo NREQ.
REQ-017 In a transfer cycle read[sel] SHALL be 1, and on the next edge dataOut SHALL load dataIn[sel] and writeOut SHALL be 1; latency from pop to write is exactly one cycle.
REQ-018 In IDLE, a transferred flit with tail=1 SHALL keep the FSM in IDLE and set ptr to sel+1, wrapping NREQ-1 to 0.
REQ-019 In IDLE, a transferred flit with tail=0 SHALL move the FSM to BUSY and lock sel.
REQ-020 In BUSY, only the locked requester SHALL be served; other req bits SHALL be ignored.
REQ-021 In BUSY with req[lock] and can_send, the flit SHALL be transferred; with tail=1 the FSM SHALL return to IDLE and ptr SHALL become lock+1 mod NREQ.
REQ-022 In any cycle with no transfer, read SHALL be 0, writeOut SHALL be 0 next cycle and dataOut SHALL hold its value.
REQ-023 grant SHALL equal read in IDLE and one-hot(lock) in BUSY.
REQ-024 busy SHALL be 1 exactly when the state is BUSY.
REQ-025 read SHALL never have more than one bit set.
REQ-026 A req deasserting mid-packet SHALL stall the port in BUSY, with no timeout.

Reset
REQ-027 While reset=0: state IDLE, ptr 0, lock 0, dataOut 0, writeOut 0, read 0, grant 0, busy 0.
REQ-028 Reset asserted mid-packet SHALL drop the packet lock immediately, with no flush of in-flight flits.

Structure
REQ-029 Shared package noc_pkg SHALL hold the requester index constants (E=0, W=1, L=2), the FSM state encoding and TAIL_BIT = WIDTH-1.
REQ-030 The rotating-priority select SHALL be the sub-module rr_pick (inputs: req vector and ptr; outputs: one-hot pick and valid).

Verification
REQ-031 Reset then req=3'b111, all flits tail=1, destination never full -> grants E, W, L, E in successive cycles; writeOut high from cycle 2 onward.
REQ-032 W sends a 3-flit packet (tail on flit 3) while E and L request -> grant fixed at 3'b010 for 3 transfers, busy=1 for 2 cycles, then grant goes to L.
REQ-033 destAlmostFull=1 with writeOut=1 -> no read that cycle; after a write, destAlmostFull with writeOut=0 -> one transfer allowed.
REQ-034 destFull=1 for 4 cycles mid-packet -> read=0 and writeOut=0 for those cycles, lock held, and the packet resumes in order afterwards.
REQ-035 ptr=2 and only L requests a tail flit -> ptr wraps to 0, and a following E and W request is served E first.
REQ-036 reset pulsed low during BUSY -> all outputs go to 0 asynchronously, and the next packet arbitrates from ptr 0.
